// File: rtl/rv_imm_pkg.sv
// Shared types for the RV32I immediate encoder: format select, opcodes and FSM states.
// The optional LUI+ADDI split is controlled by IMM_ENCODER_LI_SPLIT_EN.
package rv_imm_pkg;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_U = 3'b011,
      IMM_J = 3'b100
   } sel_imm_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [2:0] F3_ADDI    = 3'b000;

   // ST_SPLIT is only reachable when IMM_ENCODER_LI_SPLIT_EN is defined.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FULL  = 2'd1,
      ST_SPLIT = 2'd2
   } state_e;

   // True for "addi rd, x0, imm", the only shape eligible for the LUI+ADDI split.
   function automatic logic is_li_addi(input logic [31:0] base);
      return (base[6:0] == OPC_OP_IMM) && (base[14:12] == F3_ADDI) && (base[19:15] == 5'd0);
   endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate scatter and range check for the five RV32I immediate formats.
// Independent of IMM_ENCODER_LI_SPLIT_EN; the split decision lives in the top.
module imm_pack
   import rv_imm_pkg::*;
(
   input  logic [2:0]  sel,
   input  logic [31:0] base,
   input  logic [31:0] imm,
   output logic [31:0] inst,
   output logic        err
);

   always_comb begin
      inst = base;
      err  = 1'b0;
      case (sel)
         IMM_I: begin
            inst[31:20] = imm[11:0];
            err         = (imm[31:11] != {21{imm[11]}});
         end
         IMM_S: begin
            inst[31:25] = imm[11:5];
            inst[11:7]  = imm[4:0];
            err         = (imm[31:11] != {21{imm[11]}});
         end
         IMM_B: begin
            inst[31]    = imm[12];
            inst[7]     = imm[11];
            inst[30:25] = imm[10:5];
            inst[11:8]  = imm[4:1];
            err         = (imm[31:12] != {20{imm[12]}}) || imm[0];
         end
         IMM_U: begin
            inst[31:12] = imm[31:12];
            err         = (imm[11:0] != 12'd0);
         end
         IMM_J: begin
            inst[31]    = imm[20];
            inst[19:12] = imm[19:12];
            inst[20]    = imm[11];
            inst[30:21] = imm[10:1];
            err         = (imm[31:20] != {12{imm[20]}}) || imm[0];
         end
         // Unknown format: pass the base word through untouched and flag it.
         default: begin
            inst = base;
            err  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder with a one-beat output register and valid/ready on both sides.
// Define IMM_ENCODER_LI_SPLIT_EN to expand out-of-range "addi rd,x0,imm" into LUI+ADDI.
module imm_encoder
   import rv_imm_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_sel_imm,
   input  logic [31:0] req_base,
   input  logic [31:0] req_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic        out_err
);

   logic [31:0] pack_inst;
   logic        pack_err;

   imm_pack u_pack (
      .sel  (req_sel_imm),
      .base (req_base),
      .imm  (req_imm),
      .inst (pack_inst),
      .err  (pack_err)
   );

   state_e      state_reg, state_next;
   logic [31:0] inst_reg, inst_next;
   logic        err_reg, err_next;
   logic        accept, drain;

   logic [31:0] load_inst;
   logic        load_err;
   state_e      load_state;

`ifdef IMM_ENCODER_LI_SPLIT_EN
   logic [31:0] pend_reg, pend_next;
   logic        split_hit;
   logic [19:0] hi20;
   logic [31:0] lui_inst, addi_inst;

   // For I-format with a legal select, pack_err can only mean "out of range".
   assign split_hit = (req_sel_imm == IMM_I) && pack_err && is_li_addi(req_base);
   // Rounding up by imm[11] compensates for ADDI sign-extending its low 12 bits.
   assign hi20      = req_imm[31:12] + {19'd0, req_imm[11]};
   assign lui_inst  = {hi20, req_base[11:7], OPC_LUI};
   assign addi_inst = {req_imm[11:0], req_base[11:7], req_base[14:12], req_base[11:7], OPC_OP_IMM};

   always_comb begin
      if (split_hit) begin
         load_inst  = lui_inst;
         load_err   = 1'b0;
         load_state = ST_SPLIT;
      end else begin
         load_inst  = pack_inst;
         load_err   = pack_err;
         load_state = ST_FULL;
      end
   end
`else
   assign load_inst  = pack_inst;
   assign load_err   = pack_err;
   assign load_state = ST_FULL;
`endif

   assign out_valid = (state_reg != ST_IDLE);
   assign out_inst  = inst_reg;
   assign out_err   = err_reg;
   assign drain     = out_valid && out_ready;
   assign accept    = req_valid && req_ready;

   // Kept apart from the next-state logic so req_valid never feeds req_ready.
   always_comb begin
      req_ready = 1'b0;
      case (state_reg)
         ST_IDLE: req_ready = 1'b1;
         ST_FULL: req_ready = out_ready;
         default: req_ready = 1'b0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      inst_next  = inst_reg;
      err_next   = err_reg;
`ifdef IMM_ENCODER_LI_SPLIT_EN
      pend_next  = pend_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               state_next = load_state;
               inst_next  = load_inst;
               err_next   = load_err;
`ifdef IMM_ENCODER_LI_SPLIT_EN
               pend_next  = addi_inst;
`endif
            end
         end
         ST_FULL: begin
            if (drain) begin
               if (accept) begin
                  state_next = load_state;
                  inst_next  = load_inst;
                  err_next   = load_err;
`ifdef IMM_ENCODER_LI_SPLIT_EN
                  pend_next  = addi_inst;
`endif
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
`ifdef IMM_ENCODER_LI_SPLIT_EN
         ST_SPLIT: begin
            if (drain) begin
               state_next = ST_FULL;
               inst_next  = pend_reg;
               err_next   = 1'b0;
            end
         end
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         inst_reg  <= 32'h0;
         err_reg   <= 1'b0;
`ifdef IMM_ENCODER_LI_SPLIT_EN
         pend_reg  <= 32'h0;
`endif
      end else begin
         state_reg <= state_next;
         inst_reg  <= inst_next;
         err_reg   <= err_next;
`ifdef IMM_ENCODER_LI_SPLIT_EN
         pend_reg  <= pend_next;
`endif
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed scoreboard bench for imm_encoder; split expectations follow IMM_ENCODER_LI_SPLIT_EN.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_sel_imm = 3'b000;
   logic [31:0] req_base = 32'h0;
   logic [31:0] req_imm = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic        out_err;

   typedef struct packed {
      logic [31:0] inst;
      logic        err;
   } beat_t;

   beat_t sb[$];
   int compared = 0;
   int mismatched = 0;
   int beats_seen = 0;

   imm_encoder dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_sel_imm (req_sel_imm),
      .req_base    (req_base),
      .req_imm     (req_imm),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_inst    (out_inst),
      .out_err     (out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] inst, input logic err);
      beat_t b;
      b.inst = inst;
      b.err  = err;
      sb.push_back(b);
   endtask

   // Drives one request and returns after the edge that accepted it.
   task automatic send(input logic [2:0] sel, input logic [31:0] base, input logic [31:0] imm,
                       output int waits);
      logic acc;
      req_sel_imm = sel;
      req_base    = base;
      req_imm     = imm;
      req_valid   = 1'b1;
      waits       = 0;
      forever begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         waits++;
         if (waits > 50) begin
            compared++;
            mismatched++;
            $error("FAIL accept_timeout: observed no accept expected accept within 50 cycles");
            break;
         end
      end
      $display("req  sel=%0d base=%h imm=%h waits=%0d", sel, base, imm, waits);
      check("latency_valid", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic wait_empty();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("drain_timeout", sb.size(), 32'd0);
      #1;
   endtask

   // Scoreboard side: every handshaken output beat must match the oldest expectation.
   always @(negedge clk) begin
      beat_t b;
      if (!rst && out_valid && out_ready) begin
         beats_seen++;
         compared++;
         assert (sb.size() > 0) else begin
            mismatched++;
            $error("FAIL unexpected_beat: observed inst %h expected no beat", out_inst);
         end
         if (sb.size() > 0) begin
            b = sb.pop_front();
            $display("beat inst=%h err=%0d (exp %h/%0d)", out_inst, out_err, b.inst, b.err);
            check("beat_inst", out_inst, b.inst);
            check("beat_err", {31'd0, out_err}, {31'd0, b.err});
         end
      end
   end

   initial begin
      int w;
      int base_beats;
      logic exp_split_ready;

      // Reset state.
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_inst", out_inst, 32'h0);
      check("rst_out_err", {31'd0, out_err}, 32'd0);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;

      // Single I-type beat.
      push(32'h7FF00093, 1'b0);
      send(3'b000, 32'h00000093, 32'h000007FF, w);
      req_valid = 1'b0;
      wait_empty();

      // Back-to-back burst across all formats; each accept must be immediate.
      push(32'hFE112E23, 1'b0); send(3'b001, 32'h00112023, 32'hFFFFFFFC, w); check("tput_s", w, 0);
      push(32'h00000163, 1'b1); send(3'b010, 32'h00000063, 32'h00000003, w); check("tput_b_odd", w, 0);
      push(32'h80000063, 1'b1); send(3'b010, 32'h00000063, 32'h00001000, w); check("tput_b_rng", w, 0);
      push(32'hFE000CE3, 1'b0); send(3'b010, 32'h00000063, 32'hFFFFFFF8, w); check("tput_b_ok", w, 0);
      push(32'h001000EF, 1'b0); send(3'b100, 32'h000000EF, 32'h00000800, w); check("tput_j_ok", w, 0);
      push(32'h800000EF, 1'b1); send(3'b100, 32'h000000EF, 32'h00100000, w); check("tput_j_rng", w, 0);
      push(32'h123450B7, 1'b0); send(3'b011, 32'h000000B7, 32'h12345000, w); check("tput_u_ok", w, 0);
      push(32'h123450B7, 1'b1); send(3'b011, 32'h000000B7, 32'h12345001, w); check("tput_u_low", w, 0);
      push(32'h12345678, 1'b1); send(3'b101, 32'h12345678, 32'hFFFFFFFF, w); check("tput_badsel", w, 0);
      req_valid = 1'b0;
      wait_empty();

      // Out-of-range ADDI from x0.
`ifdef IMM_ENCODER_LI_SPLIT_EN
      push(32'h123460B7, 1'b0);
      push(32'hFFF08093, 1'b0);
      exp_split_ready = 1'b0;
`else
      push(32'hFFF00093, 1'b1);
      exp_split_ready = 1'b1;
`endif
      send(3'b000, 32'h00000093, 32'h12345FFF, w);
      req_valid = 1'b0;
      check("split_req_ready", {31'd0, req_ready}, {31'd0, exp_split_ready});
      wait_empty();

      // Backpressure: beat A held for 5 cycles while B waits at the input.
      base_beats = beats_seen;
      out_ready = 1'b0;
      push(32'h00500113, 1'b0);
      send(3'b000, 32'h00000113, 32'h00000005, w);
      push(32'hABCDE237, 1'b0);
      req_sel_imm = 3'b011;
      req_base    = 32'h00000237;
      req_imm     = 32'hABCDE000;
      req_valid   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_inst", out_inst, 32'h00500113);
         check("bp_err", {31'd0, out_err}, 32'd0);
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_req_ready", {31'd0, req_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(3'b011, 32'h00000237, 32'hABCDE000, w);
      check("bp_release_wait", w, 0);
      push(32'hFFF00193, 1'b0);
      send(3'b000, 32'h00000193, 32'hFFFFFFFF, w);
      check("bp_b2b_wait", w, 0);
      req_valid = 1'b0;
      wait_empty();
      check("bp_beat_count", beats_seen - base_beats, 32'd3);

      // Reset while a beat (and, with the split, a pending ADDI) is held.
      out_ready = 1'b0;
`ifdef IMM_ENCODER_LI_SPLIT_EN
      push(32'h123460B7, 1'b0);
      push(32'hFFF08093, 1'b0);
`else
      push(32'hFFF00093, 1'b1);
`endif
      send(3'b000, 32'h00000093, 32'h12345FFF, w);
      req_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", {31'd0, out_valid}, 32'd0);
      check("async_rst_inst", out_inst, 32'h0);
      sb.delete();
      base_beats = beats_seen;
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_valid", {31'd0, out_valid}, 32'd0);
      check("post_rst_no_beats", beats_seen - base_beats, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
